// File: rtl/altr_hps_rstn_seq.sv
// Reset-source sequencer for one AASD target domain: asserts tgt_rst_n, waits for the echoed ack, releases, reports done.
// Optional ack-wait timeout with sticky timeout_err is enabled by defining ALTR_HPS_RSTN_SEQ_TIMEOUT_EN.
module altr_hps_rstn_seq #(
  parameter int unsigned MIN_ASSERT_CYC = 16,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYC    = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_rst_req,
  input  logic tgt_rst_ack_n,
  input  logic scan_mode,
  output logic tgt_rst_n,
  output logic rst_busy,
  output logic rst_done
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  if (MIN_ASSERT_CYC < 2 || MIN_ASSERT_CYC > 255 ||
      MIN_ASSERT_CYC > 2**CNT_W - 1 || TIMEOUT_CYC > 2**CNT_W - 1) begin : g_bad_param
    $error("altr_hps_rstn_seq: counter parameters out of range");
  end

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE,
    ST_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT_CYC - 1);
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ack_sync;
  logic             ack_s;
  logic             req_q;
  logic             req_rise;
  logic             tgt_q;

  assign ack_s    = ack_sync[3];
  assign req_rise = sw_rst_req & ~req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
      req_q    <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[2:0], tgt_rst_ack_n};
      req_q    <= sw_rst_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      tgt_q       <= 1'b0;
      rst_busy    <= 1'b1;
      rst_done    <= 1'b0;
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      rst_done <= 1'b0;
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
      if (req_rise) timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_rise) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            tgt_q    <= 1'b0;
            rst_busy <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Release needs both the minimum hold and the ack round-trip.
          if (cnt >= HOLD_LAST && !ack_s) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            tgt_q <= 1'b1;
          end
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
          else if (cnt >= TO_LAST) begin
            state       <= ST_DONE;
            cnt         <= '0;
            tgt_q       <= 1'b1;
            rst_busy    <= 1'b0;
            rst_done    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          else if (cnt < HOLD_LAST) begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          if (ack_s) begin
            state    <= ST_DONE;
            cnt      <= '0;
            rst_busy <= 1'b0;
            rst_done <= 1'b1;
          end
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
          else if (cnt >= TO_LAST) begin
            state       <= ST_DONE;
            cnt         <= '0;
            rst_busy    <= 1'b0;
            rst_done    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          rst_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scan bypass: the raw reset drives the target directly.
  assign tgt_rst_n = scan_mode ? rst_n : tgt_q;

endmodule

// File: tb/tb_altr_hps_rstn_seq.sv
// Directed bench for altr_hps_rstn_seq with a 2-flop AASD target echoing tgt_rst_n back as the ack.
module tb_altr_hps_rstn_seq;

`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 32;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sw_rst_req = 1'b0;
  logic scan_mode = 1'b0;
  logic ack_hi = 1'b0;
  logic [1:0] echo = '0;
  logic tgt_rst_ack_n;
  logic tgt_rst_n;
  logic rst_busy;
  logic rst_done;
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
  logic timeout_err;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_low = 0;
  int k;

  typedef struct {
    logic  rst_n;
    logic  req;
    int    cycles;
    logic  tgt;
    logic  busy;
    logic  done;
    string name;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  always @(posedge clk or negedge tgt_rst_n) begin
    if (!tgt_rst_n) echo <= '0;
    else            echo <= {echo[0], 1'b1};
  end

  assign tgt_rst_ack_n = ack_hi ? 1'b1 : echo[1];

  altr_hps_rstn_seq #(
    .MIN_ASSERT_CYC(16),
    .CNT_W         (8),
    .TIMEOUT_CYC   (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_req   (sw_rst_req),
    .tgt_rst_ack_n(tgt_rst_ack_n),
    .scan_mode    (scan_mode),
    .tgt_rst_n    (tgt_rst_n),
    .rst_busy     (rst_busy),
    .rst_done     (rst_done)
`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_done) n_done++;
    if (!tgt_rst_n) n_low++;
    check("busy_done_excl", int'(rst_busy & rst_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5,  1'b0, 1'b1, 1'b0, "in_reset"};
    vecs[1] = '{1'b1, 1'b0, 15, 1'b0, 1'b1, 1'b0, "por_hold"};
    vecs[2] = '{1'b1, 1'b0, 7,  1'b1, 1'b1, 1'b0, "por_release"};
    vecs[3] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, "por_done"};
    vecs[4] = '{1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b0, "por_idle"};

    #2;
    for (int i = 0; i < 5; i++) begin
      rst_n      = vecs[i].rst_n;
      sw_rst_req = vecs[i].req;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        tick();
        check({vecs[i].name, "_tgt"},  int'(tgt_rst_n), int'(vecs[i].tgt));
        check({vecs[i].name, "_busy"}, int'(rst_busy),  int'(vecs[i].busy));
        check({vecs[i].name, "_done"}, int'(rst_done),  int'(vecs[i].done));
      end
    end

`ifndef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
    // Ack held high 40 cycles after assertion: release waits for the synced ack.
    n_low = 0; n_done = 0;
    ack_hi = 1'b1; sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (40) tick();
    ack_hi = 1'b0;
    repeat (60) tick();
    check("slow_ack_low_time", n_low, 45);
    check("slow_ack_done_cnt", n_done, 1);
    check("slow_ack_idle", int'(rst_busy), 0);
`endif

    // Held request gives one sequence; a new edge in RELEASE is dropped.
    n_done = 0;
    sw_rst_req = 1'b1;
    repeat (100) tick();
    check("held_req_done_cnt", n_done, 1);
    sw_rst_req = 1'b0;
    tick();
    n_low = 0; n_done = 0;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (18) tick();
    check("in_release_tgt", int'(tgt_rst_n), 1);
    check("in_release_busy", int'(rst_busy), 1);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (40) tick();
    check("req_in_release_done_cnt", n_done, 1);
    check("req_min_hold", n_low, 16);

    // Scan bypass: tgt_rst_n follows rst_n while the flop holds a different value.
    scan_mode = 1'b1;
    #1 check("scan_idle_tgt", int'(tgt_rst_n), 1);
    rst_n = 1'b0;
    #1 check("scan_rst_low", int'(tgt_rst_n), 0);
    rst_n = 1'b1;
    #1 check("scan_follow_high", int'(tgt_rst_n), 1);
    check("scan_fsm_busy", int'(rst_busy), 1);
    scan_mode = 1'b0;
    #1 check("scan_off_flop", int'(tgt_rst_n), 0);
    n_done = 0; n_low = 0;
    repeat (40) tick();
    check("scan_seq_done_cnt", n_done, 1);
    check("scan_seq_low", n_low, 15);

    // Reset pulse in the middle of RELEASE.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (20) tick();
    check("mid_release_tgt", int'(tgt_rst_n), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tgt", int'(tgt_rst_n), 0);
    check("mid_rst_busy", int'(rst_busy), 1);
    check("mid_rst_done", int'(rst_done), 0);
    #1 rst_n = 1'b1;
    #1;
    k = 0;
    while (k < 100) begin
      tick();
      k++;
      if (tgt_rst_n) break;
    end
    check("mid_rst_hold_cycles", k, 16);
    k = 0;
    while (k < 100) begin
      tick();
      k++;
      if (rst_done) break;
    end
    check("mid_rst_done_delay", k, 7);

`ifdef ALTR_HPS_RSTN_SEQ_TIMEOUT_EN
    // Ack stuck high: timeout forces DONE 32 cycles into ASSERT.
    repeat (3) tick();
    ack_hi = 1'b1; sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (rst_done) break;
    end
    check("timeout_done_cycles", k, 32);
    check("timeout_err_set", int'(timeout_err), 1);
    ack_hi = 1'b0;
    repeat (5) tick();
    check("timeout_err_sticky", int'(timeout_err), 1);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("timeout_err_cleared", int'(timeout_err), 0);
    repeat (40) tick();
    check("timeout_recover_err", int'(timeout_err), 0);
    check("timeout_recover_idle", int'(rst_busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
